fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, waits RD_CYCLES for instruction memory,
// then captures the word into a single-entry output register for decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          RD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] ImemAddr,
    input  logic [31:0] ImemData,
    input  logic        Redirect,
    input  logic [63:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    output logic [31:0] FetchCount
);

    if (RD_CYCLES < 1 || RD_CYCLES > 15) begin : g_bad_rd_cycles
        $error("fetch_unit: RD_CYCLES must be in 1..15");
    end

    localparam logic [3:0]  CNT_LAST         = 4'(RD_CYCLES - 1);
    localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic rd_done;
    logic capture;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^RedirectPC[1:0];

    assign rd_done = (cnt_q == CNT_LAST);
    assign capture = rd_done && (state_q == EMPTY || InstrReady) && !Redirect;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;

        if (Redirect) begin
            pc_d    = {RedirectPC[63:2], 2'b00};
            cnt_d   = 4'd0;
            state_d = EMPTY;
        end else if (capture) begin
            // ImemData is only looked at here, so garbage on other cycles is harmless.
            instr_d       = ImemData;
            instr_pc_d    = pc_q;
            state_d       = FULL;
            pc_d          = pc_q + 64'd4;
            cnt_d         = 4'd0;
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            if (!rd_done) begin
                cnt_d = cnt_q + 4'd1;
            end
            if (state_q == FULL && InstrReady) begin
                state_d = EMPTY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= EMPTY;
            pc_q          <= RESET_PC_ALIGNED;
            cnt_q         <= 4'd0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 64'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign ImemAddr   = pc_q;
    assign InstrValid = (state_q == FULL);
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: four instances cover RD_CYCLES 1/2/3 and a
// wrapping RESET_PC; inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

    localparam logic [31:0] W0   = 32'hF84003E9;
    localparam logic [31:0] W4   = 32'hF84083EA;
    localparam logic [31:0] W8   = 32'hF84103EB;
    localparam logic [31:0] W20  = 32'h8B0901AD;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;
    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   mem_word = W0;
            64'h4:   mem_word = W4;
            64'h8:   mem_word = W8;
            64'h20:  mem_word = W20;
            default: mem_word = {16'hE000, a[15:0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // u1: RD_CYCLES=1
    logic        rst1 = 1'b1, ready1 = 1'b0;
    logic [63:0] addr1, ipc1;
    logic [31:0] data1, instr1, fc1;
    logic        valid1;
    assign data1 = mem_word(addr1);
    fetch_unit #(.RESET_PC(64'h0), .RD_CYCLES(1)) u1 (
        .CLK(CLK), .Reset(rst1), .ImemAddr(addr1), .ImemData(data1),
        .Redirect(1'b0), .RedirectPC(64'h0), .InstrValid(valid1),
        .InstrReady(ready1), .Instr(instr1), .InstrPC(ipc1), .FetchCount(fc1));

    // u3: RD_CYCLES=3, memory bus carries junk except on capture cycles
    logic        rst3 = 1'b1, ready3 = 1'b0, junk3 = 1'b1;
    logic [63:0] addr3, ipc3;
    logic [31:0] data3, instr3, fc3;
    logic        valid3;
    assign data3 = junk3 ? JUNK : mem_word(addr3);
    fetch_unit #(.RESET_PC(64'h0), .RD_CYCLES(3)) u3 (
        .CLK(CLK), .Reset(rst3), .ImemAddr(addr3), .ImemData(data3),
        .Redirect(1'b0), .RedirectPC(64'h0), .InstrValid(valid3),
        .InstrReady(ready3), .Instr(instr3), .InstrPC(ipc3), .FetchCount(fc3));

    // u2: default parameters, stall / redirect / async reset
    logic        rst2 = 1'b1, ready2 = 1'b0, redir2 = 1'b0;
    logic [63:0] rpc2 = 64'h0;
    logic [63:0] addr2, ipc2;
    logic [31:0] data2, instr2, fc2;
    logic        valid2;
    assign data2 = mem_word(addr2);
    fetch_unit u2 (
        .CLK(CLK), .Reset(rst2), .ImemAddr(addr2), .ImemData(data2),
        .Redirect(redir2), .RedirectPC(rpc2), .InstrValid(valid2),
        .InstrReady(ready2), .Instr(instr2), .InstrPC(ipc2), .FetchCount(fc2));

    // u4: PC wraps through zero
    logic        rst4 = 1'b1, ready4 = 1'b0, redir4 = 1'b0;
    logic [63:0] rpc4 = 64'h0;
    logic [63:0] addr4, ipc4;
    logic [31:0] data4, instr4, fc4;
    logic        valid4;
    assign data4 = mem_word(addr4);
    fetch_unit #(.RESET_PC(TOP_PC), .RD_CYCLES(2)) u4 (
        .CLK(CLK), .Reset(rst4), .ImemAddr(addr4), .ImemData(data4),
        .Redirect(redir4), .RedirectPC(rpc4), .InstrValid(valid4),
        .InstrReady(ready4), .Instr(instr4), .InstrPC(ipc4), .FetchCount(fc4));

    initial begin
        step();
        // Reset state
        check("rst1_valid", valid1, 0);
        check("rst1_instr", instr1, 0);
        check("rst1_ipc",   ipc1,   0);
        check("rst1_fc",    fc1,    0);
        check("rst1_addr",  addr1,  0);
        check("rst4_addr",  addr4,  TOP_PC);

        // RD_CYCLES=1: one instruction per edge starting at the first edge
        rst1 = 1'b0; ready1 = 1'b1;
        step();
        check("rd1_valid0", valid1, 1);
        check("rd1_ipc0",   ipc1,   64'h0);
        check("rd1_instr0", instr1, W0);
        step();
        check("rd1_ipc1",   ipc1,   64'h4);
        check("rd1_instr1", instr1, W4);
        step();
        check("rd1_ipc2",   ipc1,   64'h8);
        check("rd1_instr2", instr1, W8);
        check("rd1_fc",     fc1,    3);
        check("rd1_addr",   addr1,  64'hC);

        // RD_CYCLES=3: capture on every third edge only
        rst3 = 1'b0; ready3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < 3; e++) begin
                junk3 = (e != 2);
                step();
                check("rd3_valid", valid3, (e == 2) ? 1 : 0);
                if (e < 2) begin
                    check("rd3_addr_dwell", addr3, 64'(4 * k));
                    check("rd3_fc_dwell",   fc3,   k);
                end else begin
                    check("rd3_addr_step", addr3, 64'(4 * k + 4));
                    check("rd3_ipc",       ipc3,  64'(4 * k));
                    check("rd3_instr",     instr3, mem_word(64'(4 * k)));
                    check("rd3_fc",        fc3,   k + 1);
                end
            end
        end
        junk3 = 1'b1;

        // RD_CYCLES=2: first capture, then 5 stalled cycles
        rst2 = 1'b0; ready2 = 1'b1;
        step();
        check("stall_wait_valid", valid2, 0);
        step();
        check("stall_first_instr", instr2, W0);
        check("stall_first_addr",  addr2,  64'h4);
        ready2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_hold_valid", valid2, 1);
            check("stall_hold_instr", instr2, W0);
            check("stall_hold_ipc",   ipc2,   64'h0);
            check("stall_hold_addr",  addr2,  64'h4);
        end
        ready2 = 1'b1;
        step();
        check("stall_release_instr", instr2, W4);
        check("stall_release_ipc",   ipc2,   64'h4);
        check("stall_release_valid", valid2, 1);
        check("stall_release_addr",  addr2,  64'h8);
        check("stall_release_fc",    fc2,    2);

        // Redirect while FULL and not ready
        ready2 = 1'b0;
        step();
        check("pre_redir_hold", instr2, W4);
        redir2 = 1'b1; rpc2 = 64'h23;
        step();
        check("redir_valid", valid2, 0);
        check("redir_addr",  addr2,  64'h20);
        check("redir_fc",    fc2,    2);
        redir2 = 1'b0; ready2 = 1'b1;
        step();
        check("redir_wait_valid", valid2, 0);
        step();
        check("redir_instr", instr2, W20);
        check("redir_ipc",   ipc2,   64'h20);
        check("redir_addr2", addr2,  64'h24);
        check("redir_fc2",   fc2,    3);

        // Get FULL with PC at 0x14, then pulse reset between edges
        redir2 = 1'b1; rpc2 = 64'h10;
        step();
        redir2 = 1'b0;
        step();
        step();
        ready2 = 1'b0;
        check("pre_rst_valid", valid2, 1);
        check("pre_rst_addr",  addr2,  64'h14);
        check("pre_rst_ipc",   ipc2,   64'h10);
        #2 rst2 = 1'b1;
        #1;
        check("arst_valid", valid2, 0);
        check("arst_instr", instr2, 0);
        check("arst_ipc",   ipc2,   0);
        check("arst_fc",    fc2,    0);
        check("arst_addr",  addr2,  64'h0);
        step();
        rst2 = 1'b0; ready2 = 1'b1;
        step();
        check("post_rst_wait", valid2, 0);
        step();
        check("post_rst_instr", instr2, W0);
        check("post_rst_ipc",   ipc2,   64'h0);
        check("post_rst_fc",    fc2,    1);

        // PC wrap from the top of the address space
        rst4 = 1'b0; ready4 = 1'b1;
        step();
        step();
        check("wrap_ipc0",   ipc4,   TOP_PC);
        check("wrap_instr0", instr4, mem_word(TOP_PC));
        check("wrap_addr0",  addr4,  64'h0);
        step();
        check("wrap_drain_valid", valid4, 0);
        step();
        check("wrap_ipc1",   ipc4,   64'h0);
        check("wrap_instr1", instr4, W0);
        check("wrap_fc",     fc4,    2);

        // Redirect wins over a capture that would otherwise happen on the same edge
        ready4 = 1'b0;
        step();
        redir4 = 1'b1; rpc4 = 64'h8; ready4 = 1'b1;
        step();
        redir4 = 1'b0;
        check("redir_prio_valid", valid4, 0);
        check("redir_prio_addr",  addr4,  64'h8);
        check("redir_prio_fc",    fc4,    2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
